// File: rtl/regfile_write_sched.sv
// Purpose: shares the single register-file write port between pipeline writeback and a
//          DEPTH-entry long-latency return FIFO, and runs a zero-clear of x1..x31 after reset.
// Latency: write port is combinational (captured by the regfile at the same edge); an accepted
//          long-latency result can be written at the next edge. Backpressure: lu_ready drops
//          while the FIFO is full or during the clear; wb_hold asks the pipeline to yield
//          when the FIFO head has waited STARVE_LIMIT cycles.
// Ports:
//   clk, rst (async, active-low)
//   wb_valid/wb_addr/wb_data   : pipeline writeback, no ready, always wins the port
//   lu_valid/lu_ready/lu_addr/lu_data : long-latency result handshake
//   wren/waddr/wdata           : register-file write port
//   pend_mask                  : bit i set while any queued entry targets xi
//   wb_hold                    : pipeline should present no writeback this cycle
//   init_busy                  : clear sequence in progress
module regfile_write_sched #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        wren,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pend_mask,
  output logic        wb_hold,
  output logic        init_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [4:0]      icnt_q, icnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   age_q, age_d;
  logic            wb_hold_q, wb_hold_d;
  logic [4:0]      ent_addr_q [DEPTH];
  logic [4:0]      ent_addr_d [DEPTH];
  logic [31:0]     ent_data_q [DEPTH];
  logic [31:0]     ent_data_d [DEPTH];

  logic run, fifo_empty, fifo_full, wb_wins, pop, push;

  assign run        = (state_q == S_RUN);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  // A writeback to x0 writes nothing, so it must not steal the port from the FIFO.
  assign wb_wins    = run && wb_valid && (wb_addr != 5'd0);
  assign pop        = run && !wb_wins && !fifo_empty;
  // No pass-through: a full FIFO refuses even when it pops this cycle.
  assign lu_ready   = run && !fifo_full;
  // x0 results complete the handshake but are dropped.
  assign push       = lu_ready && lu_valid && (lu_addr != 5'd0);
  assign init_busy  = !run;
  assign wb_hold    = wb_hold_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      icnt_q     <= 5'd1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      age_q      <= '0;
      wb_hold_q  <= 1'b0;
      ent_addr_q <= '{default: '0};
      ent_data_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      icnt_q     <= icnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      wb_hold_q  <= wb_hold_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    icnt_d     = icnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    age_d      = age_q;
    wb_hold_d  = wb_hold_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;

    if (!run) begin
      icnt_d = icnt_q + 5'd1;
      if (icnt_q == 5'd31) begin
        state_d = S_RUN;
      end
    end

    if (push) begin
      ent_addr_d[wr_ptr_q] = lu_addr;
      ent_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Age counts cycles the head has been passed over; it saturates at the limit.
    if (!run || fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q != AW'(STARVE_LIMIT)) begin
      age_d = age_q + AW'(1);
    end

    // Hold stays up through further writebacks until the starved head finally drains.
    if (pop) begin
      wb_hold_d = 1'b0;
    end else if (age_d == AW'(STARVE_LIMIT)) begin
      wb_hold_d = 1'b1;
    end
  end

  // Output logic: write-port mux
  always_comb begin
    wren  = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;
    // Held low while rst is asserted so the regfile sees no clear write during reset.
    if (rst) begin
      if (!run) begin
        wren  = 1'b1;
        waddr = icnt_q;
      end else if (wb_wins) begin
        wren  = 1'b1;
        waddr = wb_addr;
        wdata = wb_data;
      end else if (pop) begin
        wren  = 1'b1;
        waddr = ent_addr_q[rd_ptr_q];
        wdata = ent_data_q[rd_ptr_q];
      end
    end
  end

  // Output logic: pending mask over occupied slots (slot offset from head < count)
  always_comb begin
    logic [PW-1:0] off;
    off       = '0;
    pend_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        pend_mask[ent_addr_q[i]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
module tb_regfile_write_sched;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        wren;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pend_mask;
  logic        wb_hold;
  logic        init_busy;

  always #5 clk = ~clk;

  regfile_write_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_addr   (lu_addr),
    .lu_data   (lu_data),
    .wren      (wren),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_mask (pend_mask),
    .wb_hold   (wb_hold),
    .init_busy (init_busy)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model: queue of pending results, clear-sequence index, starvation age.
  ent_t        m_q[$];
  bit          m_init;
  int          m_icnt;
  int          m_age;
  bit          m_hold;
  logic [31:0] m_rf   [32];
  logic [31:0] dut_rf [32];

  int n_tests = 0;
  int n_fail  = 0;
  int dut_wr_cnt = 0;
  int x0_wr_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_init = 1'b1;
    m_icnt = 1;
    m_age  = 0;
    m_hold = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_wren"},      wren,      32'd0);
    chk({pfx, "_waddr"},     waddr,     32'd0);
    chk({pfx, "_wdata"},     wdata,     32'd0);
    chk({pfx, "_lu_ready"},  lu_ready,  32'd0);
    chk({pfx, "_pend"},      pend_mask, 32'd0);
    chk({pfx, "_wb_hold"},   wb_hold,   32'd0);
    chk({pfx, "_init_busy"}, init_busy, 32'd1);
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] ep;
    bit          er, was_init, was_empty, popped, acc;
    ent_t        e;
    @(negedge clk);
    if (!rst) begin
      chk_reset_vals("rst");
    end else begin
      ew = 1'b0; ea = 5'd0; ed = 32'd0;
      if (m_init) begin
        ew = 1'b1; ea = 5'(m_icnt);
      end else if (wb_valid && wb_addr != 5'd0) begin
        ew = 1'b1; ea = wb_addr; ed = wb_data;
      end else if (m_q.size() > 0) begin
        ew = 1'b1; ea = m_q[0].a; ed = m_q[0].d;
      end
      ep = 32'd0;
      foreach (m_q[k]) ep[m_q[k].a] = 1'b1;
      er = !m_init && (m_q.size() < DEPTH);
      chk("wren", wren, ew);
      if (ew) begin
        chk("waddr", waddr, ea);
        chk("wdata", wdata, ed);
      end
      chk("lu_ready", lu_ready, er);
      chk("pend_mask", pend_mask, ep);
      chk("wb_hold", wb_hold, m_hold);
      chk("init_busy", init_busy, m_init);
    end
    if (wren === 1'b1) begin
      dut_wr_cnt++;
      if (waddr == 5'd0) x0_wr_cnt++;
      dut_rf[waddr] = wdata;
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      was_init  = m_init;
      was_empty = (m_q.size() == 0);
      popped    = 1'b0;
      acc       = !m_init && (m_q.size() < DEPTH) && lu_valid;
      if (m_init) begin
        m_rf[m_icnt] = 32'd0;
        m_icnt++;
        if (m_icnt > 31) m_init = 1'b0;
      end else if (wb_valid && wb_addr != 5'd0) begin
        m_rf[wb_addr] = wb_data;
      end else if (!was_empty) begin
        e = m_q.pop_front();
        m_rf[e.a] = e.d;
        popped = 1'b1;
      end
      if (!was_init) begin
        if (popped || was_empty) m_age = 0;
        else m_age++;
        if (popped) m_hold = 1'b0;
        else if (m_age >= LIMIT) m_hold = 1'b1;
      end
      if (acc && lu_addr != 5'd0) m_q.push_back('{lu_addr, lu_data});
    end
    #1;
  endtask

  task automatic run_init(input string tag);
    int base;
    base = dut_wr_cnt;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk({tag, "_first_wren"},  wren,  32'd1);
    chk({tag, "_first_waddr"}, waddr, 32'd1);
    chk({tag, "_first_wdata"}, wdata, 32'd0);
    repeat (31) step();
    chk({tag, "_writes"}, dut_wr_cnt - base, 32'd31);
    #1;
    chk({tag, "_busy_c32"},  init_busy, 32'd0);
    chk({tag, "_ready_c32"}, lu_ready,  32'd1);
  endtask

  initial begin
    bit busy;
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = 32'd0;
      dut_rf[i] = 32'd0;
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    step();
    step();
    rst = 1'b1;
    run_init("init");

    // Single long-latency result to x5 with the port free.
    step();
    drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("x5_pend",  pend_mask[5], 32'd1);
    chk("x5_wren",  wren,         32'd1);
    chk("x5_waddr", waddr,        32'd5);
    chk("x5_wdata", wdata,        32'hDEADBEEF);
    step();
    #1;
    chk("x5_pend_clr", pend_mask, 32'd0);
    chk("x5_rf", dut_rf[5], 32'hDEADBEEF);
    step();

    // Two results to x7 then one to x9 while writeback occupies the port.
    drive(1, 5'd10, 32'hA, 1, 5'd7, 32'h1);
    step();
    drive(1, 5'd10, 32'hB, 1, 5'd7, 32'h2);
    step();
    drive(1, 5'd10, 32'hC, 1, 5'd9, 32'h3);
    #1;
    chk("full_ready", lu_ready, 32'd0);
    chk("full_pend7", pend_mask[7], 32'd1);
    step();
    drive(0, 0, 0, 1, 5'd9, 32'h3);
    #1;
    chk("drain1_waddr", waddr, 32'd7);
    chk("drain1_wdata", wdata, 32'h1);
    chk("drain1_ready", lu_ready, 32'd0);
    step();
    drive(0, 0, 0, 1, 5'd9, 32'h3);
    #1;
    chk("drain2_wdata", wdata, 32'h2);
    chk("drain2_pend7", pend_mask[7], 32'd1);
    chk("drain2_ready", lu_ready, 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("after_pend7", pend_mask[7], 32'd0);
    chk("after_pend9", pend_mask[9], 32'd1);
    chk("x7_final", dut_rf[7], 32'h2);
    step();

    // Starvation: writeback to x3 every cycle while x12 waits.
    drive(1, 5'd3, 32'h30, 1, 5'd12, 32'h12345678);
    step();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'd3, 32'(k), 0, 0, 0);
      #1;
      chk($sformatf("hold_pre%0d", k), wb_hold, 32'd0);
      step();
    end
    drive(1, 5'd3, 32'h35, 0, 0, 0);
    #1;
    chk("hold_rise", wb_hold, 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("hold_drain_waddr", waddr, 32'd12);
    chk("hold_drain_hold",  wb_hold, 32'd1);
    step();
    #1;
    chk("hold_clear", wb_hold, 32'd0);
    step();

    // x0 on both sides: handshake completes, nothing written or queued.
    drive(1, 5'd0, 32'hFF, 1, 5'd0, 32'h55);
    #1;
    chk("x0_ready", lu_ready,  32'd1);
    chk("x0_wren",  wren,      32'd0);
    chk("x0_pend",  pend_mask, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("x0_pend_after", pend_mask, 32'd0);
    step();

    // Reset with two entries queued.
    drive(1, 5'd10, 32'hE, 1, 5'd13, 32'h13);
    step();
    drive(1, 5'd10, 32'hF, 1, 5'd14, 32'h14);
    step();
    drive(1, 5'd10, 32'hF, 0, 0, 0);
    #1;
    chk("pre_rst_pend", pend_mask, (32'd1 << 13) | (32'd1 << 14));
    rst = 1'b0;
    #1;
    chk_reset_vals("abort");
    step();
    step();
    rst = 1'b1;
    run_init("reinit");
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("no_stale", wren, 32'd0);
      step();
    end

    // Randomized traffic with alternating busy/quiet writeback phases.
    busy = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) busy = 1'($urandom_range(0, 1));
      drive(busy ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom());
      step();
    end

    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rf_x%0d", i), dut_rf[i], m_rf[i]);
    end
    chk("x0_writes", x0_wr_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
